// File: rtl/img_mem_read.sv
`default_nettype none
// ============================================================================
// Module   : img_mem_read
// Brief    : Row-major image RAM reader with a 2-entry tagged output buffer.
// Revision : 1.0 - initial release
// ============================================================================
module img_mem_read #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic [4:0]        pix_row,
    output logic [4:0]        pix_col,
    output logic              pix_last,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [4:0] c_LAST_COL = 5'(IMG_W - 1);
    localparam logic [4:0] c_LAST_ROW = 5'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_busy;
    logic                   r_done;
    logic [ADDR_W-1:0]      r_addr;
    logic [4:0]             r_row;
    logic [4:0]             r_col;

    logic                   r_inflight;
    logic [4:0]             r_tag_row;
    logic [4:0]             r_tag_col;
    logic                   r_tag_last;

    logic [1:0][DATA_W-1:0] r_buf_data;
    logic [1:0][4:0]        r_buf_row;
    logic [1:0][4:0]        r_buf_col;
    logic [1:0]             r_buf_last;
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;

    logic [2:0]             w_committed;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_issue;
    logic                   w_issue_last;

    // A read may go out only if its data is guaranteed a buffer slot on return.
    assign w_committed  = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_pop        = (r_count != 2'd0) && pix_ready;
    assign w_push       = r_inflight;
    assign w_issue      = (r_state == S_READ) &&
                          ((w_committed <= 3'd1) || ((w_committed == 3'd2) && w_pop));
    assign w_issue_last = (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);

    assign mem_addr  = r_addr;
    assign mem_rd_en = w_issue;
    assign pix_valid = (r_count != 2'd0);
    assign pix_data  = r_buf_data[r_rd_ptr];
    assign pix_row   = r_buf_row[r_rd_ptr];
    assign pix_col   = r_buf_col[r_rd_ptr];
    assign pix_last  = r_buf_last[r_rd_ptr];
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_addr  <= '0;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_READ;
                        r_busy  <= 1'b1;
                        r_addr  <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        if (r_col == c_LAST_COL) begin
                            r_col <= '0;
                            r_row <= r_row + 5'd1;
                        end else begin
                            r_col <= r_col + 5'd1;
                        end
                        if (w_issue_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Leave as the final buffered pixel is handed over.
                    if (w_pop && (r_count == 2'd1) && !r_inflight) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_inflight <= 1'b0;
            r_tag_row  <= '0;
            r_tag_col  <= '0;
            r_tag_last <= 1'b0;
            r_buf_data <= '0;
            r_buf_row  <= '0;
            r_buf_col  <= '0;
            r_buf_last <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag_row  <= r_row;
                r_tag_col  <= r_col;
                r_tag_last <= w_issue_last;
            end
            if (w_push) begin
                r_buf_data[r_wr_ptr] <= mem_rdata;
                r_buf_row[r_wr_ptr]  <= r_tag_row;
                r_buf_col[r_wr_ptr]  <= r_tag_col;
                r_buf_last[r_wr_ptr] <= r_tag_last;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

endmodule
`default_nettype wire
